// File: rtl/pwm_fade_gen_if.sv
// pwm_fade_gen_if: control and status bundle between the light FSM and the PWM fade generator
interface pwm_fade_gen_if #(parameter int CNT_WIDTH = 10);
  logic                 i_enable;
  logic                 i_fade_en;
  logic [CNT_WIDTH-1:0] i_duty;
  logic                 o_pwm;
  logic                 o_period_tick;
  logic [CNT_WIDTH-1:0] o_duty_cur;
  logic                 o_busy;
  modport master (output i_enable, i_fade_en, i_duty, input o_pwm, o_period_tick, o_duty_cur, o_busy);
  modport slave  (input i_enable, i_fade_en, i_duty, output o_pwm, o_period_tick, o_duty_cur, o_busy);
endinterface

// File: rtl/pwm_fade_gen.sv
// pwm_fade_gen: period-synchronous PWM with optional per-period duty ramp toward the target
module pwm_fade_gen #(
  parameter int CNT_WIDTH = 10,
  parameter int PERIOD    = 1000,
  parameter int FADE_STEP = 10
) (
  input logic           i_clk,
  input logic           i_reset_n,
  pwm_fade_gen_if.slave bus
);
  localparam int W = CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] LP_PERIOD = CNT_WIDTH'(PERIOD);
  localparam logic [CNT_WIDTH-1:0] LP_LAST   = CNT_WIDTH'(PERIOD - 1);
  localparam logic [CNT_WIDTH:0]   LP_STEP   = W'(FADE_STEP);
  typedef enum logic {IDLE, RUN} state_t;
  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt, r_d_cur, w_tgt, w_next;
  logic [CNT_WIDTH:0]   w_cur, w_tgt_x, w_up, w_dn;
  logic                 w_last;
  // ramp arithmetic is one bit wider so step overshoot and underflow are caught before clamping
  always_comb begin
    w_tgt   = (bus.i_duty > LP_PERIOD) ? LP_PERIOD : bus.i_duty;
    w_cur   = {1'b0, r_d_cur};
    w_tgt_x = {1'b0, w_tgt};
    w_up    = w_cur + LP_STEP;
    w_dn    = (w_cur > LP_STEP) ? w_cur - LP_STEP : '0;
    w_next  = !bus.i_fade_en ? w_tgt :
              (w_cur < w_tgt_x) ? ((w_up > w_tgt_x) ? w_tgt : w_up[CNT_WIDTH-1:0]) :
              (w_cur > w_tgt_x) ? ((w_dn < w_tgt_x) ? w_tgt : w_dn[CNT_WIDTH-1:0]) : r_d_cur;
    w_last  = (r_state == RUN) && (r_cnt == LP_LAST);
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_d_cur <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
      if (bus.i_enable) begin
        r_state <= RUN;
        if (!bus.i_fade_en) r_d_cur <= w_tgt;
      end
    end else begin
      r_cnt <= (w_last || !bus.i_enable) ? '0 : r_cnt + CNT_WIDTH'(1);
      if (w_last) r_d_cur <= w_next;
      if (!bus.i_enable) r_state <= IDLE;
    end
  end
  assign bus.o_pwm         = (r_state == RUN) && (r_cnt < r_d_cur);
  assign bus.o_period_tick = w_last;
  assign bus.o_duty_cur    = r_d_cur;
  assign bus.o_busy        = (r_state == RUN) && bus.i_fade_en && (r_d_cur != w_tgt);
endmodule

// File: tb/tb_pwm_fade_gen.sv
// tb_pwm_fade_gen: per-period scoreboard of high-time, applied duty and busy against a duty-sequence model
module tb_pwm_fade_gen;
  localparam int CW = 10, P = 1000, S = 10;
  logic clk = 0, rst_n = 1;
  always #5 clk = ~clk;
  pwm_fade_gen_if #(.CNT_WIDTH(CW)) bus();
  pwm_fade_gen #(.CNT_WIDTH(CW), .PERIOD(P), .FADE_STEP(S)) dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));
  typedef struct {int duty; bit busy;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_fail = 0, model_d = 0;
  int hi = 0, pos = 0, glitch = 0;
  bit mon_en = 0, prev = 0;
  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int clamp(int d);
    return d > P ? P : d;
  endfunction
  // applied duty for the following period given the one in force and the boundary inputs
  function automatic int nxt(int d, int duty, bit fade);
    int t = clamp(duty);
    if (!fade || d == t) return t;
    if (d < t) return (d + S > t) ? t : d + S;
    return (d - S < t) ? t : d - S;
  endfunction
  task automatic step(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic enable_run(int duty, bit fade);
    bus.i_duty = CW'(duty); bus.i_fade_en = fade; bus.i_enable = 1;
    if (!fade) model_d = clamp(duty);
    step(1);
    mon_en = 1;
  endtask
  // entered at cnt 0; inputs change at cnt 'at' and are what the closing boundary samples
  task automatic run_period(int duty, bit fade, int at);
    step(at);
    bus.i_duty = CW'(duty); bus.i_fade_en = fade;
    q.push_back('{duty: model_d, busy: fade && model_d != clamp(duty)});
    model_d = nxt(model_d, duty, fade);
    step(P - at);
  endtask
  always @(negedge clk) begin
    if (!mon_en) begin
      hi = 0; pos = 0; glitch = 0; prev = 0;
    end else begin
      if (bus.o_pwm && !prev && pos != 0) glitch++;
      if (bus.o_pwm) hi++;
      prev = bus.o_pwm;
      pos++;
      if (bus.o_period_tick) begin
        if (q.size() == 0) check("unexpected_tick", 1, 0);
        else begin
          e = q.pop_front();
          check("high_count", hi, e.duty);
          check("duty_cur", int'(bus.o_duty_cur), e.duty);
          check("busy_at_tick", int'(bus.o_busy), int'(e.busy));
          check("tick_spacing", pos, P);
          check("no_runt", glitch, 0);
        end
        hi = 0; pos = 0; glitch = 0;
      end
    end
  end
  initial begin
    bus.i_enable = 0; bus.i_fade_en = 0; bus.i_duty = '0;
    #1 rst_n = 0;
    #2;
    check("rst_pwm", int'(bus.o_pwm), 0);
    check("rst_tick", int'(bus.o_period_tick), 0);
    check("rst_duty", int'(bus.o_duty_cur), 0);
    check("rst_busy", int'(bus.o_busy), 0);
    #20 rst_n = 1;
    step(2);
    enable_run(300, 0);
    run_period(300, 0, 400);
    run_period(300, 0, 400);
    run_period(700, 0, 500);
    run_period(0, 0, 250);
    run_period(1000, 0, 600);
    run_period(1023, 0, 10);
    run_period(1023, 0, 10);
    run_period(0, 0, 999);
    repeat (11) run_period(95, 1, 500);
    check("fade_up_end", int'(bus.o_duty_cur), 95);
    repeat (10) run_period(0, 1, 500);
    check("fade_down_end", int'(bus.o_duty_cur), 0);
    repeat (8) run_period(int'($urandom_range(0, 1023)), bit'($urandom_range(0, 1)), int'($urandom_range(1, P - 1)));
    run_period(300, 0, 500);
    step(150);
    check("pwm_before_disable", int'(bus.o_pwm), 1);
    mon_en = 0; bus.i_enable = 0;
    step(1);
    check("disable_pwm", int'(bus.o_pwm), 0);
    check("disable_duty_hold", int'(bus.o_duty_cur), 300);
    step(5);
    check("idle_pwm", int'(bus.o_pwm), 0);
    check("idle_tick", int'(bus.o_period_tick), 0);
    enable_run(300, 0);
    run_period(300, 0, 700);
    run_period(800, 1, 100);
    run_period(800, 1, 100);
    step(200);
    mon_en = 0;
    #1 rst_n = 0;
    #1;
    check("async_rst_pwm", int'(bus.o_pwm), 0);
    check("async_rst_busy", int'(bus.o_busy), 0);
    check("async_rst_tick", int'(bus.o_period_tick), 0);
    check("async_rst_duty", int'(bus.o_duty_cur), 0);
    model_d = 0; bus.i_enable = 0;
    #1 rst_n = 1;
    step(3);
    check("post_rst_idle_pwm", int'(bus.o_pwm), 0);
    check("post_rst_idle_busy", int'(bus.o_busy), 0);
    check("post_rst_idle_duty", int'(bus.o_duty_cur), 0);
    enable_run(200, 0);
    run_period(200, 0, 300);
    run_period(200, 0, 300);
    check("scoreboard_drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
